// File: rtl/sound_pkg.sv
// Shared sound codes, player state type and elaboration helpers for the sound path.
package sound_pkg;

    localparam logic [1:0] SND_PING = 2'b00;
    localparam logic [1:0] SND_PONG = 2'b01;
    localparam logic [1:0] SND_GO   = 2'b10;
    localparam logic [1:0] SND_STOP = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycles per half period of a square wave at freq_hz.
    function automatic int half_cycles(input int clk_hz, input int freq_hz);
        return clk_hz / (2 * freq_hz);
    endfunction

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave phase generator: toggles phase every `half` cycles while enabled.
module tone_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] half,
    input  logic             restart,
    input  logic             enable,
    output logic             phase,
    output logic             phase_next
);

    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] half_cnt_next;

    // phase_next is exported so the owner can register an output aligned with phase.
    always_comb begin
        half_cnt_next = '0;
        phase_next    = 1'b0;
        if (restart) begin
            half_cnt_next = '0;
            phase_next    = 1'b1;
        end else if (enable) begin
            if (half_cnt == half - CNT_W'(1)) begin
                half_cnt_next = '0;
                phase_next    = ~phase;
            end else begin
                half_cnt_next = half_cnt + CNT_W'(1);
                phase_next    = phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            half_cnt <= half_cnt_next;
            phase    <= phase_next;
        end
    end

endmodule

// File: rtl/sound_player.sv
// Plays one fixed-length square-wave tone per change of code_sound; mute gates only the pin.
module sound_player
    import sound_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int F_PING   = 440,
    parameter int F_PONG   = 880,
    parameter int F_GO     = 660,
    parameter int F_STOP   = 220,
    parameter int DUR_MS   = 100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] code_playing
);

    // state | meaning
    // IDLE  | no tone, speaker low, waiting for a code change
    // PLAY  | tone running for DUR_CYC cycles, restartable by a new code

    localparam int HALF_PING = half_cycles(CLK_FREQ, F_PING);
    localparam int HALF_PONG = half_cycles(CLK_FREQ, F_PONG);
    localparam int HALF_GO   = half_cycles(CLK_FREQ, F_GO);
    localparam int HALF_STOP = half_cycles(CLK_FREQ, F_STOP);
    // 64-bit product: default 100 ms at 25 MHz exceeds the int range.
    localparam int DUR_CYC   = int'((longint'(DUR_MS) * longint'(CLK_FREQ)) / 64'sd1000);
    localparam int HALF_MAX  = max2(max2(HALF_PING, HALF_PONG), max2(HALF_GO, HALF_STOP));
    localparam int CNT_W     = $clog2(max2(DUR_CYC, HALF_MAX) + 1);

    if (HALF_PING < 1 || HALF_PONG < 1 || HALF_GO < 1 || HALF_STOP < 1) begin : g_bad_half
        $error("sound_player: a tone half period is shorter than one clock");
    end
    if (DUR_CYC < 1) begin : g_bad_dur
        $error("sound_player: tone duration is shorter than one clock");
    end

    state_t           state;
    state_t           state_next;
    logic [1:0]       last_code;
    logic             primed;
    logic             trigger;
    logic [CNT_W-1:0] dur_cnt;
    logic [CNT_W-1:0] half_sel;
    logic             phase;
    logic             phase_next;

    assign trigger = primed && (code_sound != last_code);

    always_comb begin
        half_sel = CNT_W'(HALF_PING);
        unique case (code_playing)
            SND_PING: half_sel = CNT_W'(HALF_PING);
            SND_PONG: half_sel = CNT_W'(HALF_PONG);
            SND_GO:   half_sel = CNT_W'(HALF_GO);
            SND_STOP: half_sel = CNT_W'(HALF_STOP);
        endcase
    end

    // A code change on the final duration cycle restarts rather than ends the tone.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = PLAY;
            PLAY:    if (!trigger && dur_cnt == CNT_W'(DUR_CYC - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= IDLE;
            last_code    <= SND_PING;
            primed       <= 1'b0;
            dur_cnt      <= '0;
            busy         <= 1'b0;
            speaker      <= 1'b0;
            code_playing <= SND_PING;
        end else begin
            state     <= state_next;
            last_code <= code_sound;
            primed    <= 1'b1;
            busy      <= (state_next == PLAY);
            speaker   <= phase_next & ~mute & (state_next == PLAY);
            if (trigger) begin
                code_playing <= code_sound;
                dur_cnt      <= '0;
            end else if (state_next == PLAY) begin
                dur_cnt <= dur_cnt + CNT_W'(1);
            end else begin
                dur_cnt <= '0;
            end
        end
    end

    tone_gen #(
        .CNT_W(CNT_W)
    ) u_tone_gen (
        .clk        (clk),
        .clr        (clr),
        .half       (half_sel),
        .restart    (trigger),
        .enable     (state_next == PLAY),
        .phase      (phase),
        .phase_next (phase_next)
    );

endmodule
